// File: rtl/reg_bank_wb.sv
// reg_bank_wb: 32x32 register bank with a one-entry write-back buffer and bypassing read ports
// Ports:
//   clk, reset (async, active-low)
//   reg_write, wr_addr, wr_data : write strobe, destination and data (captured into the buffer)
//   rs_addr/rs_data, rt_addr/rt_data : combinational read ports with buffer bypass
//   wr_pending : buffer holds an uncommitted write
module reg_bank_wb #(
  parameter logic [31:0] SP_INIT = 32'd227,
  parameter logic [31:0] RA_INIT = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic        wr_pending
);
  logic [31:0] regs [32];
  logic [4:0]  buf_addr;
  logic [31:0] buf_data;
  logic        buf_valid;
  logic        cap;
  assign cap = reg_write && wr_addr != 5'd0;
  // buf_valid is never set for r0, so regs[0] keeps its reset value of zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= i == 29 ? SP_INIT : i == 31 ? RA_INIT : 32'd0;
      buf_valid <= 1'b0;
      buf_addr  <= 5'd0;
      buf_data  <= 32'd0;
    end else begin
      if (buf_valid) regs[buf_addr] <= buf_data;
      buf_valid <= cap;
      if (cap) begin
        buf_addr <= wr_addr;
        buf_data <= wr_data;
      end
    end
  always_comb begin
    rs_data = rs_addr == 5'd0 ? 32'd0 : (buf_valid && buf_addr == rs_addr) ? buf_data : regs[rs_addr];
    rt_data = rt_addr == 5'd0 ? 32'd0 : (buf_valid && buf_addr == rt_addr) ? buf_data : regs[rt_addr];
  end
  assign wr_pending = buf_valid;
endmodule

// File: tb/tb_reg_bank_wb.sv
// tb_reg_bank_wb: self-checking bench for reg_bank_wb using a pending-write queue model
module tb_reg_bank_wb;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_write = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic [4:0]  rs_addr = 5'd0;
  logic [4:0]  rt_addr = 5'd0;
  logic [31:0] rs_data, rt_data;
  logic        wr_pending;
  int n_chk = 0;
  int n_fail = 0;
  bit started = 1'b0;
  reg_bank_wb #(.SP_INIT(32'd227), .RA_INIT(32'd0)) dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data), .wr_pending(wr_pending)
  );
  always #5 clk = ~clk;
  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  logic [31:0] m_arr [32];
  wr_t pend [$];
  // writes become architecturally visible on the edge that accepts them and
  // reach the array one edge later; a reset drops anything not yet stored
  always @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_arr[i] = 32'd0;
      m_arr[29] = 32'd227;
      m_arr[31] = 32'd0;
      pend.delete();
    end else begin
      if (pend.size() > 0) begin
        m_arr[pend[0].a] = pend[0].d;
        void'(pend.pop_front());
      end
      if (reg_write && wr_addr != 5'd0) pend.push_back('{wr_addr, wr_data});
    end
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].a == a) return pend[i].d;
    return m_arr[a];
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (started) begin
      chk("model_rs", rs_data, m_read(rs_addr));
      chk("model_rt", rt_data, m_read(rt_addr));
      chk("model_pending", {31'd0, wr_pending}, {31'd0, pend.size() != 0});
    end
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    reg_write = we;
    wr_addr = wa;
    wr_data = wd;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #3 reset = 1'b0;
    rs_addr = 5'd29; rt_addr = 5'd31;
    #1;
    chk("reset_sp", rs_data, 32'd227);
    chk("reset_ra", rt_data, 32'd0);
    chk("reset_pending", {31'd0, wr_pending}, 32'd0);
    rs_addr = 5'd5; rt_addr = 5'd0;
    #1;
    chk("reset_r5", rs_data, 32'd0);
    chk("reset_r0", rt_data, 32'd0);
    #4 reset = 1'b1;
    started = 1'b1;
    step(1'b1, 5'd8, 32'hDEADBEEF);
    rs_addr = 5'd8;
    #1;
    chk("bypass_r8", rs_data, 32'hDEADBEEF);
    chk("pending_r8", {31'd0, wr_pending}, 32'd1);
    step(1'b0, 5'd0, 32'd0);
    #1;
    chk("commit_pending", {31'd0, wr_pending}, 32'd0);
    chk("array_r8", rs_data, 32'hDEADBEEF);
    step(1'b1, 5'd0, 32'h1234);
    rs_addr = 5'd0; rt_addr = 5'd8;
    #1;
    chk("r0_pending", {31'd0, wr_pending}, 32'd0);
    chk("r0_read", rs_data, 32'd0);
    chk("r0_r8_intact", rt_data, 32'hDEADBEEF);
    rs_addr = 5'd8;
    #1;
    chk("same_addr_ports", rs_data ^ rt_data, 32'd0);
    chk("same_addr_val", rs_data, 32'hDEADBEEF);
    rt_addr = 5'd31;
    step(1'b1, 5'd31, 32'd4);
    chk("b2b_ra_first", rt_data, 32'd4);
    step(1'b1, 5'd31, 32'd8);
    chk("b2b_ra_bypass", rt_data, 32'd8);
    step(1'b0, 5'd0, 32'd0);
    chk("b2b_ra_array", rt_data, 32'd8);
    chk("b2b_ra_pending", {31'd0, wr_pending}, 32'd0);
    step(1'b1, 5'd29, 32'd100);
    step(1'b1, 5'd2, 32'd7);
    rs_addr = 5'd29; rt_addr = 5'd2;
    #1;
    chk("b2b_sp_array", rs_data, 32'd100);
    chk("b2b_r2_bypass", rt_data, 32'd7);
    step(1'b0, 5'd0, 32'd0);
    chk("b2b_r2_array", rt_data, 32'd7);
    step(1'b1, 5'd3, 32'd55);
    rs_addr = 5'd3; rt_addr = 5'd29;
    #1;
    chk("midw_bypass", rs_data, 32'd55);
    chk("midw_pending", {31'd0, wr_pending}, 32'd1);
    reg_write = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    #1 reset = 1'b0;
    #1;
    chk("midw_r3_reset", rs_data, 32'd0);
    chk("midw_pending_reset", {31'd0, wr_pending}, 32'd0);
    chk("midw_sp_reset", rt_data, 32'd227);
    #4 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midw_no_commit", rs_data, 32'd0);
    chk("midw_no_pending", {31'd0, wr_pending}, 32'd0);
    step(1'b1, 5'd17, 32'hA5A5_0001);
    step(1'b1, 5'd18, 32'h5A5A_0002);
    step(1'b1, 5'd17, 32'hFFFF_FFFF);
    rs_addr = 5'd17; rt_addr = 5'd18;
    #1;
    chk("mix_r17", rs_data, 32'hFFFF_FFFF);
    chk("mix_r18", rt_data, 32'h5A5A_0002);
    step(1'b0, 5'd0, 32'd0);
    step(1'b0, 5'd0, 32'd0);
    started = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_bank_wb.md
# reg_bank_wb

Register bank with a one-entry write-back buffer. It sits directly downstream of the write-register selector mux and the write-data path in the multicycle datapath. It receives the selected destination register number, including the fixed $sp (29) and $ra (31) selections, plus the write data and the control unit's write strobe. It provides two asynchronous read ports (rs, rt) with bypass from the pending write, so the control FSM never sees stale data.

## Interface
- SP_INIT, 32'd227, reset value of register 29 ($sp)
- RA_INIT, 32'd0, reset value of register 31 ($ra)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears buffer and array to reset values
- reg_write  in  1  write strobe from control unit, sampled on rising clk
- wr_addr  in  5  destination register; connected to selector mux data_out[4:0]
- wr_data  in  32  write-back data
- rs_addr  in  5  read port A address
- rt_addr  in  5  read port B address
- rs_data  out  32  read port A data (combinational)
- rt_data  out  32  read port B data (combinational)
- wr_pending  out  1  high while the buffer holds an uncommitted write

## Operation
- Storage: 32 x 32-bit array; r0 is hardwired 0 and is never stored.
- Write path is two-stage:
  - Capture edge: if reg_write=1 and wr_addr!=0, load buf_addr<=wr_addr, buf_data<=wr_data, buf_valid<=1.
  - Commit edge: the next rising edge writes array[buf_addr]<=buf_data if buf_valid.
- Capture and commit on the same edge:
  - The old entry commits and the new one captures.
  - Back-to-back writes sustain 1 per cycle.
- If reg_write=0 or wr_addr=0 on an edge, buf_valid<=0 after the commit.
- Read ports, each independently:
  - addr=0 -> 0.
  - Else if buf_valid and buf_addr==addr -> buf_data (bypass).
  - Else -> array[addr].
- Same-address consecutive writes: the newer value wins. Bypass shows the newest value; the array ends with the newest value after the final commit.
- wr_pending = buf_valid.

## Timing
- Reset (reset=0, asynchronous, any time):
  - Array: all zero, except r29=SP_INIT and r31=RA_INIT.
  - buf_valid=0, buf_addr=0, buf_data=0, wr_pending=0.
  - rs_data and rt_data reflect the reset array immediately: 0, or SP_INIT when addr=29.
- Reset asserted mid-operation: any pending write is discarded (not committed). Reset deassertion takes effect on the next rising clk.
- Write latency:
  - Edge N captures; rs_data/rt_data show the new value via bypass from edge N, after clk-to-q.
  - Edge N+1 commits to the array.
  - Effective read-after-write latency is one edge.
- Read latency is 0 cycles (combinational from address, array and buffer).
- Simultaneous events:
  - Capture to X while committing to Y: both occur; reads of Y return the array value and reads of X return the bypass value.
  - rs_addr==rt_addr: both ports return identical data.
- No stall or backpressure; reg_write is accepted every cycle.

## Test plan
- Reset check: pulse reset low mid-cycle -> rs_addr=29 gives 227, rs_addr=31 gives 0, rs_addr=5 gives 0, wr_pending=0, all without a clock edge.
- Basic write/bypass: reg_write=1, wr_addr=8, wr_data=32'hDEADBEEF at edge N.
  - After edge N: rs_addr=8 gives DEADBEEF and wr_pending=1.
  - After edge N+1 (reg_write=0): wr_pending=0 and DEADBEEF comes from the array.
- r0 protection: write 32'h1234 to addr 0 -> wr_pending stays 0, rs_addr=0 reads 0, no array entry changes.
- Back-to-back same register: edge N writes r31=4, edge N+1 writes r31=8.
  - After N+1: rt_addr=31 gives 8.
  - After N+2: 8 from the array.
  - At no point after edge N+1 is 4 visible.
- Back-to-back different registers: edge N writes r29=100, edge N+1 writes r2=7.
  - After N+1: rs=29 gives 100 (array) and rt=2 gives 7 (bypass).
- Reset mid-write: capture r3=55, then assert reset before the next edge -> r3 reads 0, wr_pending=0, and no commit occurs after reset release.
